hist_run_ctrl: RTL
==================

# hist_run_ctrl

Run controller for the LFSR histogram datapath. On a start command it clears every histogram bin, drives the LFSR/binning path for a programmed number of samples, and waits out the binning pipeline. It then reads each bin out over a valid/ready stream and pulses done. It sits between the system/host side and `lfsr_histogram_top`'s LFSR and histogram memory, and is the only master of their enable, clear and read ports.

## Interface
- `NUM_BINS`, 8: number of histogram bins, ≥2.
- `BIN_ADDR_W`, 3: bin address width; must satisfy 2^BIN_ADDR_W ≥ NUM_BINS.
- `BIN_CNT_W`, 16: width of each bin count.
- `CNT_W`, 16: sample-count width.
- `HIST_LAT`, 2: cycles from a `bin_wr_en` cycle until that bin update is visible in memory, ≥0.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a run; sampled only in IDLE.
- `num_samples`  in  CNT_W  number of samples; latched on an accepted start.
- `abort`  in  1  cancels a run from any non-IDLE state.
- `lfsr_en`  out  1  advances the LFSR by one sample.
- `bin_wr_en`  out  1  histogram increments the bin of the current sample.
- `clr_en`  out  1  zeroes the bin at `clr_addr`.
- `clr_addr`  out  BIN_ADDR_W  bin being cleared.
- `rd_en`  out  1  read request to the histogram.
- `rd_addr`  out  BIN_ADDR_W  bin being read.
- `rd_data`  in  BIN_CNT_W  bin count, valid in the cycle after `rd_en`.
- `out_valid`  out  1  readout beat is valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_bin`  out  BIN_ADDR_W  bin index of the beat.
- `out_count`  out  BIN_CNT_W  registered count of the beat.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at run completion.
- `samples_done`  out  CNT_W  samples issued in the current or last run.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, RD_REQ, RD_WAIT, RD_OUT, DONE.
- Reset (async, any state):
  - Controller returns to IDLE.
  - All outputs go to 0: `clr_addr`, `rd_addr`, `out_bin`, `out_count` and `samples_done` are 0, and every strobe is low.
- IDLE + `start` = 1:
  - `num_samples` is latched and `samples_done` is cleared.
  - Next state is CLEAR with bin index 0.
  - `start` is ignored in every other state.
- CLEAR:
  - `clr_en` = 1 with `clr_addr` = bin index, one bin per cycle from 0 to NUM_BINS-1.
  - After the last bin, go to RUN, or to DRAIN if the latched count is 0.
- RUN:
  - `lfsr_en` and `bin_wr_en` are both 1 every cycle.
  - `samples_done` increments each cycle.
  - Leave RUN after exactly `num_samples` cycles.
- DRAIN: hold for HIST_LAT cycles with all strobes low, then go to RD_REQ with bin index 0. With HIST_LAT = 0, DRAIN is skipped.
- RD_REQ: `rd_en` = 1 and `rd_addr` = bin index for one cycle, then RD_WAIT.
- RD_WAIT: capture `rd_data` into `out_count` and the bin index into `out_bin`, then RD_OUT.
- RD_OUT:
  - `out_valid` = 1; `out_bin` and `out_count` are held stable until the handshake.
  - When `out_valid` and `out_ready` are both 1, advance to the next bin's RD_REQ, or to DONE after bin NUM_BINS-1.
- DONE: `done` = 1 for one cycle, then IDLE. `busy` is still 1 during DONE.
- `abort` in any non-IDLE state:
  - The controller is in IDLE on the next cycle and all strobes drop.
  - `done` is not pulsed.
  - `samples_done` holds its partial value.
- Precedence: `rst` over `abort` over normal transitions.
- `samples_done` saturates at 2^CNT_W-1 and cannot exceed the latched count.

## Timing
- Cycle numbering: the edge that accepts `start` is E0, and cycle k is the k-th cycle after E0.
- For N samples with `out_ready` held at 1:
  - CLEAR: cycles 1..NUM_BINS.
  - RUN: the next N cycles.
  - DRAIN: the next HIST_LAT cycles.
  - Readout: 3 cycles per bin.
  - `done` in cycle NUM_BINS + N + HIST_LAT + 3·NUM_BINS + 1.
- Each cycle `out_ready` is low in RD_OUT adds one cycle.
- A new run may start in the first IDLE cycle after DONE.
- Strobes are registered state decodes with no combinational input-to-output paths. The exception is the `out_ready` effect, which is visible only from the next cycle.

## Test plan
- **Basic run:** NUM_BINS=8, HIST_LAT=2, `num_samples`=20, `out_ready`=1.
  - `clr_en` in cycles 1-8 with `clr_addr` 0..7.
  - `lfsr_en` high in cycles 9-28.
  - `rd_en` in cycles 31, 34, …, 52.
  - 8 beats with `out_bin` 0..7 and counts summing to 20.
  - `done` in cycle 55; `samples_done` = 20.
- **Zero samples:** `num_samples`=0.
  - `lfsr_en` never asserts.
  - 8 beats, all with `out_count` = 0.
  - `done` in cycle 35.
- **Readout backpressure:** `out_ready` held low for 5 cycles on beat 3.
  - `out_bin` = 3 and `out_count` stay stable throughout.
  - `done` is 5 cycles later than in the basic run.
- **Abort in RUN:** assert `abort` in cycle 15 of the basic run.
  - IDLE in cycle 16 with all strobes low.
  - No `done` pulse; `samples_done` = 7.
  - A following start runs normally.
- **Start ignored while busy:** pulse `start` in cycle 12 with `num_samples`=99.
  - The run continues with N = 20.
- **Reset mid-operation:** assert `rst` during RD_OUT.
  - All outputs are 0 immediately (asynchronous), with no clock edge needed.
  - The controller is in IDLE after `rst` is released.

Source files
------------

// File: rtl/hist_run_ctrl.sv
// rtl/hist_run_ctrl.sv - run controller for the LFSR histogram datapath
//
// Clears all histogram bins, runs the LFSR/binning path for a latched number
// of samples, waits out the binning pipeline, streams every bin out over a
// valid/ready beat and pulses done.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, num_samples  run request (IDLE only) and its sample count
//   abort               cancel a run from any non-IDLE state
//   lfsr_en, bin_wr_en  advance the LFSR / bin the current sample
//   clr_en, clr_addr    zero one histogram bin
//   rd_en, rd_addr      histogram read request; rd_data returns next cycle
//   out_valid/out_ready readout beat handshake carrying out_bin/out_count
//   busy, done          run in progress / one-cycle completion pulse
//   samples_done        samples issued in the current or last run
module hist_run_ctrl #(
  parameter int NUM_BINS   = 8,
  parameter int BIN_ADDR_W = 3,
  parameter int BIN_CNT_W  = 16,
  parameter int CNT_W      = 16,
  parameter int HIST_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic                  abort,
  output logic                  lfsr_en,
  output logic                  bin_wr_en,
  output logic                  clr_en,
  output logic [BIN_ADDR_W-1:0] clr_addr,
  output logic                  rd_en,
  output logic [BIN_ADDR_W-1:0] rd_addr,
  input  logic [BIN_CNT_W-1:0]  rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_ADDR_W-1:0] out_bin,
  output logic [BIN_CNT_W-1:0]  out_count,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      samples_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT,
    S_DONE
  } state_t;

  // Drain counter runs 0..HIST_LAT-1; keep at least one bit so the
  // declaration stays legal when the drain phase is unused.
  localparam int DRAIN_W = (HIST_LAT < 2) ? 1 : $clog2(HIST_LAT);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'((HIST_LAT > 0) ? HIST_LAT - 1 : 0);
  localparam logic [BIN_ADDR_W-1:0] LAST_BIN   = BIN_ADDR_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
  // With no binning latency the pipeline wait is skipped entirely.
  localparam state_t AFTER_FILL = (HIST_LAT == 0) ? S_RD_REQ : S_DRAIN;

  state_t                state;
  state_t                state_nxt;
  logic [BIN_ADDR_W-1:0] idx;
  logic [CNT_W-1:0]      num_lat;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [CNT_W:0]        sd_inc;
  logic                  last_sample;

  // One extra bit so the compare cannot wrap at the top of the count range.
  assign sd_inc      = {1'b0, samples_done} + {{CNT_W{1'b0}}, 1'b1};
  assign last_sample = (sd_inc == {1'b0, num_lat});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR:   if (idx == LAST_BIN) state_nxt = (num_lat == '0) ? AFTER_FILL : S_RUN;
      S_RUN:     if (last_sample) state_nxt = AFTER_FILL;
      S_DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = S_RD_REQ;
      S_RD_REQ:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_RD_OUT;
      S_RD_OUT:  if (out_ready) state_nxt = (idx == LAST_BIN) ? S_DONE : S_RD_REQ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      num_lat      <= '0;
      samples_done <= '0;
      drain_cnt    <= '0;
      out_bin      <= '0;
      out_count    <= '0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_lat      <= num_samples;
            samples_done <= '0;
            idx          <= '0;
          end
        end
        S_CLEAR: begin
          idx <= (idx == LAST_BIN) ? '0 : idx + 1'b1;
        end
        S_RUN: begin
          // The sample issued in this cycle is counted even if abort ends
          // the run at this edge, so the partial count stays accurate.
          if (samples_done != CNT_MAX) samples_done <= samples_done + 1'b1;
        end
        S_RD_WAIT: begin
          out_count <= rd_data;
          out_bin   <= idx;
        end
        S_RD_OUT: begin
          if (out_ready) idx <= (idx == LAST_BIN) ? '0 : idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign lfsr_en   = (state == S_RUN);
  assign bin_wr_en = (state == S_RUN);
  assign clr_en    = (state == S_CLEAR);
  assign clr_addr  = (state == S_CLEAR) ? idx : '0;
  assign rd_en     = (state == S_RD_REQ);
  assign rd_addr   = (state == S_RD_REQ) ? idx : '0;
  assign out_valid = (state == S_RD_OUT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
